// File: rtl/v_issue_ctrl.sv
// In-order single-issue sequencer for the vector coprocessor: buffers instructions,
// starts one execution unit per head instruction, waits for completion, then writes back.
module v_issue_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SLDU_LAT = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] issue_instr,
  input  logic [2:0]  dec_unit,
  input  logic        dec_x_dest,
  output logic        start_lanes,
  output logic        start_red,
  output logic        start_sldu,
  output logic        start_lsu,
  input  logic        done_lanes,
  input  logic        done_red,
  input  logic        done_lsu,
  output logic        cfg_wr_en,
  output logic        v_reg_wr_en,
  output logic        x_reg_wr_en,
  output logic        busy,
  output logic        illegal,
  output logic        err_timeout
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(SLDU_LAT + 1);

  localparam logic [2:0] U_CFG  = 3'd0;
  localparam logic [2:0] U_ALU  = 3'd1;
  localparam logic [2:0] U_MUL  = 3'd2;
  localparam logic [2:0] U_RED  = 3'd3;
  localparam logic [2:0] U_SLDU = 3'd4;
  localparam logic [2:0] U_LSU  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT,
    S_WB
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    unit_q, unit_d;
  logic          xdest_q, xdest_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] sld_q, sld_d;

  logic start_lanes_q, start_lanes_d;
  logic start_red_q, start_red_d;
  logic start_sldu_q, start_sldu_d;
  logic start_lsu_q, start_lsu_d;
  logic cfg_wr_en_q, cfg_wr_en_d;
  logic v_reg_wr_en_q, v_reg_wr_en_d;
  logic x_reg_wr_en_q, x_reg_wr_en_d;
  logic illegal_q, illegal_d;
  logic err_timeout_q, err_timeout_d;

  logic [31:0] mem_q [DEPTH];

  logic empty, full, push, pop, unit_done;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  // Gated by nrst so the port reads 0 while reset is held, 1 as soon as it lifts.
  assign instr_ready = nrst && !full;
  assign push        = instr_valid && instr_ready;
  assign issue_instr = empty ? '0 : mem_q[rd_ptr_q];
  assign busy        = !empty || (state_q != S_IDLE);

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    unit_d        = unit_q;
    xdest_d       = xdest_q;
    tmo_d         = tmo_q;
    sld_d         = sld_q;
    err_timeout_d = err_timeout_q;
    start_lanes_d = 1'b0;
    start_red_d   = 1'b0;
    start_sldu_d  = 1'b0;
    start_lsu_d   = 1'b0;
    cfg_wr_en_d   = 1'b0;
    v_reg_wr_en_d = 1'b0;
    x_reg_wr_en_d = 1'b0;
    illegal_d     = 1'b0;
    pop           = 1'b0;
    unit_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        unit_d  = dec_unit;
        xdest_d = dec_x_dest;
        tmo_d   = '0;
        state_d = S_WAIT;
        case (dec_unit)
          U_CFG: begin
            cfg_wr_en_d = 1'b1;
            pop         = 1'b1;
            state_d     = S_IDLE;
          end
          U_ALU, U_MUL: start_lanes_d = 1'b1;
          U_RED:        start_red_d   = 1'b1;
          U_SLDU: begin
            start_sldu_d = 1'b1;
            sld_d        = SW'(SLDU_LAT);
          end
          U_LSU:        start_lsu_d   = 1'b1;
          default: begin
            illegal_d = 1'b1;
            pop       = 1'b1;
            state_d   = S_IDLE;
          end
        endcase
      end
      S_WAIT: begin
        case (unit_q)
          U_ALU, U_MUL: unit_done = done_lanes;
          U_RED:        unit_done = done_red;
          U_LSU:        unit_done = done_lsu;
          U_SLDU: begin
            unit_done = (sld_q == SW'(1));
            if (sld_q != '0) sld_d = sld_q - SW'(1);
          end
          default:      unit_done = 1'b0;
        endcase
        if (unit_done) begin
          state_d = S_WB;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th wait: abandon the instruction without writeback.
          err_timeout_d = 1'b1;
          pop           = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WB: begin
        if (xdest_q) x_reg_wr_en_d = 1'b1;
        else         v_reg_wr_en_d = 1'b1;
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      unit_q        <= '0;
      xdest_q       <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      sld_q         <= '0;
      start_lanes_q <= 1'b0;
      start_red_q   <= 1'b0;
      start_sldu_q  <= 1'b0;
      start_lsu_q   <= 1'b0;
      cfg_wr_en_q   <= 1'b0;
      v_reg_wr_en_q <= 1'b0;
      x_reg_wr_en_q <= 1'b0;
      illegal_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      unit_q        <= unit_d;
      xdest_q       <= xdest_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      sld_q         <= sld_d;
      start_lanes_q <= start_lanes_d;
      start_red_q   <= start_red_d;
      start_sldu_q  <= start_sldu_d;
      start_lsu_q   <= start_lsu_d;
      cfg_wr_en_q   <= cfg_wr_en_d;
      v_reg_wr_en_q <= v_reg_wr_en_d;
      x_reg_wr_en_q <= x_reg_wr_en_d;
      illegal_q     <= illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // NOTE: FIFO storage has no reset; entries are only visible through count, which is reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instr;
  end

  assign start_lanes = start_lanes_q;
  assign start_red   = start_red_q;
  assign start_sldu  = start_sldu_q;
  assign start_lsu   = start_lsu_q;
  assign cfg_wr_en   = cfg_wr_en_q;
  assign v_reg_wr_en = v_reg_wr_en_q;
  assign x_reg_wr_en = x_reg_wr_en_q;
  assign illegal     = illegal_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed self-checking bench for v_issue_ctrl (DEPTH=4, SLDU_LAT=2, TIMEOUT=8).
// A tiny decoder model maps issue_instr bits [30:28] to the unit and bit 31 to x-dest.
module tb_v_issue_ctrl;

  logic        clk;
  logic        nrst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] issue_instr;
  logic [2:0]  dec_unit;
  logic        dec_x_dest;
  logic        start_lanes, start_red, start_sldu, start_lsu;
  logic        done_lanes, done_red, done_lsu;
  logic        cfg_wr_en, v_reg_wr_en, x_reg_wr_en;
  logic        busy, illegal, err_timeout;

  int tests_run;
  int tests_failed;

  v_issue_ctrl #(
    .DEPTH    (4),
    .SLDU_LAT (2),
    .TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .issue_instr (issue_instr),
    .dec_unit    (dec_unit),
    .dec_x_dest  (dec_x_dest),
    .start_lanes (start_lanes),
    .start_red   (start_red),
    .start_sldu  (start_sldu),
    .start_lsu   (start_lsu),
    .done_lanes  (done_lanes),
    .done_red    (done_red),
    .done_lsu    (done_lsu),
    .cfg_wr_en   (cfg_wr_en),
    .v_reg_wr_en (v_reg_wr_en),
    .x_reg_wr_en (x_reg_wr_en),
    .busy        (busy),
    .illegal     (illegal),
    .err_timeout (err_timeout)
  );

  // Word 0x57 is the plan's alu example; every other word carries its unit in [30:28].
  assign dec_unit   = (issue_instr == 32'h0000_0057) ? 3'd1 : issue_instr[30:28];
  assign dec_x_dest = issue_instr[31];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] starts();
    return {start_lanes, start_red, start_sldu, start_lsu};
  endfunction

  function automatic logic [3:0] enables();
    return {cfg_wr_en, v_reg_wr_en, x_reg_wr_en, illegal};
  endfunction

  // Wait (bounded) for the next start pulse, check which unit and which word, answer with
  // the matching done in that first WAIT cycle, then check the writeback two cycles later.
  task automatic exec_expect(input string tag, input logic [31:0] word, input int done_sel,
                             input logic exp_x);
    int n;
    logic [3:0] exp_start;
    n = 0;
    exp_start = (done_sel == 0) ? 4'b1000 : (done_sel == 1) ? 4'b0100 : 4'b0001;
    do begin
      tick();
      n++;
    end while (starts() == 4'b0000 && n < 12);
    check({tag, "_start"}, {28'd0, starts()}, {28'd0, exp_start});
    check({tag, "_word"}, issue_instr, word);
    case (done_sel)
      0:       done_lanes = 1'b1;
      1:       done_red   = 1'b1;
      default: done_lsu   = 1'b1;
    endcase
    tick();
    done_lanes = 1'b0;
    done_red   = 1'b0;
    done_lsu   = 1'b0;
    tick();
    check({tag, "_wb"}, {30'd0, v_reg_wr_en, x_reg_wr_en}, {30'd0, !exp_x, exp_x});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    nrst         = 1'b0;
    instr_valid  = 1'b0;
    instr        = '0;
    done_lanes   = 1'b0;
    done_red     = 1'b0;
    done_lsu     = 1'b0;

    // Reset state.
    #1;
    check("rst_starts", {28'd0, starts()}, 32'd0);
    check("rst_enables", {28'd0, enables()}, 32'd0);
    check("rst_busy_err", {30'd0, busy, err_timeout}, 32'd0);
    check("rst_issue", issue_instr, 32'd0);
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    tick();
    nrst = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

    // Single alu instruction: start in cycle 2, writeback in cycle 4 after the push.
    instr_valid = 1'b1;
    instr       = 32'h0000_0057;
    tick();
    instr_valid = 1'b0;
    check("t1_c0_issue", issue_instr, 32'h0000_0057);
    check("t1_c0_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_c1_start", {28'd0, starts()}, 32'd0);
    tick();
    check("t1_c2_start", {28'd0, starts()}, 32'b1000);
    done_lanes = 1'b1;
    tick();
    done_lanes = 1'b0;
    check("t1_c3_wb", {31'd0, v_reg_wr_en}, 32'd0);
    check("t1_c3_start", {28'd0, starts()}, 32'd0);
    tick();
    check("t1_c4_vwb", {30'd0, v_reg_wr_en, x_reg_wr_en}, 32'b10);
    check("t1_c4_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t1_c5_vwb", {31'd0, v_reg_wr_en}, 32'd0);

    // Five back-to-back pushes into a 4-deep FIFO while the head stalls in WAIT.
    instr_valid = 1'b1;
    instr       = 32'h1000_00A0;
    tick();
    check("t2_p0_ready", {31'd0, instr_ready}, 32'd1);
    instr = 32'h2000_00A1;
    tick();
    instr = 32'h3000_00A2;
    tick();
    check("t2_p2_start", {28'd0, starts()}, 32'b1000);
    check("t2_p2_head", issue_instr, 32'h1000_00A0);
    instr = 32'h5000_00A3;
    tick();
    check("t2_p3_full", {31'd0, instr_ready}, 32'd0);
    instr = 32'h1000_00A4;
    tick();
    check("t2_p4_full", {31'd0, instr_ready}, 32'd0);
    check("t2_p4_head", issue_instr, 32'h1000_00A0);
    done_lanes = 1'b1;
    tick();
    done_lanes = 1'b0;
    check("t2_p5_full", {31'd0, instr_ready}, 32'd0);
    tick();
    check("t2_p6_vwb", {31'd0, v_reg_wr_en}, 32'd1);
    check("t2_p6_head", issue_instr, 32'h2000_00A1);
    check("t2_p6_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    check("t2_p7_refull", {31'd0, instr_ready}, 32'd0);
    exec_expect("t2_w1", 32'h2000_00A1, 0, 1'b0);
    exec_expect("t2_w2", 32'h3000_00A2, 1, 1'b0);
    exec_expect("t2_w3", 32'h5000_00A3, 2, 1'b0);
    exec_expect("t2_w4", 32'h1000_00A4, 0, 1'b0);
    tick();
    check("t2_idle_busy", {31'd0, busy}, 32'd0);

    // Reduction to x register; foreign done inputs are ignored in WAIT.
    instr_valid = 1'b1;
    instr       = 32'hB000_00B0;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("t3_start", {28'd0, starts()}, 32'b0100);
    done_lanes = 1'b1;
    done_lsu   = 1'b1;
    tick();
    done_lanes = 1'b0;
    done_lsu   = 1'b0;
    done_red   = 1'b1;
    check("t3_foreign_done", {30'd0, v_reg_wr_en, x_reg_wr_en}, 32'd0);
    tick();
    done_red = 1'b0;
    check("t3_wb_state", {30'd0, v_reg_wr_en, x_reg_wr_en}, 32'd0);
    tick();
    check("t3_xwb", {30'd0, v_reg_wr_en, x_reg_wr_en}, 32'b01);
    tick();
    check("t3_xwb_end", {30'd0, v_reg_wr_en, x_reg_wr_en}, 32'd0);

    // Slide: WB state two cycles after start_sldu, registered enable one cycle later.
    instr_valid = 1'b1;
    instr       = 32'h4000_00C0;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("t4_start", {28'd0, starts()}, 32'b0010);
    tick();
    check("t4_s1", {31'd0, v_reg_wr_en}, 32'd0);
    tick();
    check("t4_s2", {31'd0, v_reg_wr_en}, 32'd0);
    tick();
    check("t4_s3_vwb", {30'd0, v_reg_wr_en, x_reg_wr_en}, 32'b10);

    // Config instruction: cfg_wr_en only.
    instr_valid = 1'b1;
    instr       = 32'h0000_00D7;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("t4_cfg_en", {28'd0, enables()}, 32'b1000);
    check("t4_cfg_starts", {28'd0, starts()}, 32'd0);
    check("t4_cfg_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t4_cfg_end", {28'd0, enables()}, 32'd0);

    // LSU never completes: abort after 8 WAIT cycles, then the queued alu runs.
    instr_valid = 1'b1;
    instr       = 32'h5000_00E0;
    tick();
    instr = 32'h1000_00E1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("t5_start", {28'd0, starts()}, 32'b0001);
    repeat (7) tick();
    check("t5_w8_err", {31'd0, err_timeout}, 32'd0);
    check("t5_w8_head", issue_instr, 32'h5000_00E0);
    tick();
    check("t5_err", {31'd0, err_timeout}, 32'd1);
    check("t5_no_wb", {30'd0, v_reg_wr_en, x_reg_wr_en}, 32'd0);
    check("t5_next_head", issue_instr, 32'h1000_00E1);
    exec_expect("t5_next", 32'h1000_00E1, 0, 1'b0);
    check("t5_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset in WAIT with three entries queued.
    instr_valid = 1'b1;
    instr       = 32'h1000_0F00;
    tick();
    instr = 32'h1000_0F01;
    tick();
    instr = 32'h1000_0F02;
    tick();
    instr_valid = 1'b0;
    tick();
    check("t6_pre_busy", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    #1;
    check("t6_rst_outs", {24'd0, starts(), enables()}, 32'd0);
    check("t6_rst_status", {30'd0, busy, err_timeout}, 32'd0);
    check("t6_rst_issue", issue_instr, 32'd0);
    tick();
    nrst       = 1'b1;
    done_lanes = 1'b1;
    tick();
    done_lanes = 1'b0;
    tick();
    tick();
    check("t6_late_done", {29'd0, v_reg_wr_en, x_reg_wr_en, busy}, 32'd0);
    check("t6_ready", {31'd0, instr_ready}, 32'd1);

    // Illegal instruction: one illegal pulse, nothing else.
    instr_valid = 1'b1;
    instr       = 32'h7000_00F0;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("t7_illegal", {24'd0, starts(), enables()}, 32'b0000_0001);
    check("t7_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t7_illegal_end", {31'd0, illegal}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/v_issue_ctrl.md
Name: v_issue_ctrl

Overview:
- In-order, single-issue sequencer between the base processor and the vector coprocessor datapath.
- Buffers incoming vector instructions in a small FIFO and presents the head instruction to v_decoder.
- Starts exactly one execution unit (lanes, reduction, slide, LSU) per instruction, waits for completion, then pulses the single-cycle writeback/config enables.
- Reports busy, illegal and timeout status to the base processor.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of two, >=2).
- SLDU_LAT, 2, fixed slide-unit latency in cycles after start (>=1).
- TIMEOUT, 255, maximum WAIT cycles before abort (>=1).

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- instr_valid  in  1  base processor offers an instruction.
- instr  in  32  offered instruction word.
- instr_ready  out  1  FIFO can accept; equals !full.
- issue_instr  out  32  FIFO head word, fed to v_decoder and the operand muxes; 0 when empty.
- dec_unit  in  3  decoder class of issue_instr: 0 cfg, 1 alu, 2 mul, 3 red, 4 sldu, 5 lsu, 6/7 illegal.
- dec_x_dest  in  1  1 = result goes to the scalar x register (v_sel_dest scalar).
- start_lanes, start_red, start_sldu, start_lsu  out  1 each  one-cycle unit start pulses.
- done_lanes, done_red, done_lsu  in  1 each  unit completion pulses or levels.
- cfg_wr_en  out  1  one-cycle vcsr write enable.
- v_reg_wr_en  out  1  one-cycle vector regfile write enable.
- x_reg_wr_en  out  1  one-cycle scalar writeback enable.
- busy  out  1  !empty or state != IDLE.
- illegal  out  1  one-cycle pulse when an illegal instruction is dropped.
- err_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- **Reset** (nrst low, asynchronous):
  - FIFO emptied, pointers and count 0, state IDLE, counters 0.
  - All outputs 0, except instr_ready = 1 once out of reset.
  - An instruction in flight is discarded; no writeback occurs.
- **FIFO**:
  - Push on instr_valid && instr_ready. Pop only in the states marked "pop" below.
  - Pointers wrap modulo DEPTH. count has range 0..DEPTH.
  - Push and pop in the same cycle: count is unchanged and the word order is preserved.
  - Full: instr_ready = 0, so instr_valid is ignored.
  - Empty: issue_instr = 0 and no dispatch.
- **FSM states**: IDLE, DISPATCH, WAIT, WB.
  - IDLE: if !empty, go to DISPATCH.
  - DISPATCH:
    - Register dec_unit into unit_q and dec_x_dest into xdest_q.
    - cfg: cfg_wr_en = 1 for this cycle, pop, go to IDLE.
    - Illegal (6/7): illegal = 1, pop, go to IDLE, no enables.
    - alu/mul: start_lanes = 1. red: start_red = 1. sldu: start_sldu = 1, load slide counter = SLDU_LAT. lsu: start_lsu = 1.
    - For all four: clear timeout counter, go to WAIT.
  - WAIT:
    - Completion means done_lanes for alu/mul, done_red for red, done_lsu for lsu, or slide counter decremented to 0 for sldu.
    - Done inputs not belonging to unit_q are ignored in WAIT. All done inputs are ignored outside WAIT.
    - A done asserted in the first WAIT cycle is accepted, so minimum compute latency is 1 WAIT cycle.
    - On completion, go to WB.
    - Otherwise the timeout counter increments each cycle. When it reaches TIMEOUT: set err_timeout, pop, go to IDLE, no writeback.
  - WB:
    - xdest_q = 1: x_reg_wr_en = 1. Otherwise v_reg_wr_en = 1. Exactly one of the two for one cycle.
    - Pop, go to IDLE.
- **Timing**:
  - issue_instr must remain stable from DISPATCH through WB: the head is not popped before that, and pushes never alter the head entry.
  - Minimum occupancy: compute instruction 4 cycles (IDLE, DISPATCH, WAIT, WB); cfg or illegal 2 cycles.
  - The next instruction enters DISPATCH no earlier than one cycle after IDLE.
- **Exclusivity**: at most one start_*, cfg_wr_en, v_reg_wr_en or x_reg_wr_en is high in any cycle.
- **Registration**: all outputs are registered, except instr_ready, issue_instr and busy, which are combinational from registered state.

Test Plan:
- Reset, then push 32'h0000_0057 with dec_unit = 1 and done_lanes one cycle after start. Expect start_lanes in cycle 2 and v_reg_wr_en in cycle 4 after the push; busy falls the next cycle.
- Push 5 instructions back-to-back with DEPTH = 4 while the head is stalled in WAIT. Expect instr_ready = 0 after the 4th push, the 5th held off, and execution order equal to push order.
- Reduction with dec_x_dest = 1 and done_red. Expect x_reg_wr_en = 1 for one cycle and v_reg_wr_en = 0 throughout.
- sldu with SLDU_LAT = 2 and no done inputs. Expect WB exactly 2 cycles after start_sldu. Then a cfg instruction: expect cfg_wr_en pulse, no start_* and no writeback.
- lsu with done_lsu never asserted and TIMEOUT = 8. Expect err_timeout set 8 WAIT cycles later, the entry dropped, and the next queued instruction dispatched.
- Reset asserted mid-WAIT with 3 entries queued. Expect all outputs 0 immediately and count 0; a late done_lanes after reset produces no writeback. Also an illegal instruction (dec_unit = 7): illegal pulses once and no enables.
